rf_write_arb: RTL and testbench
===============================

Name: rf_write_arb

Overview:
- Arbitrates the single register-file write port between two sources: the in-order writeback stage and the out-of-order results of the multi-cycle multiply/divide unit (MDU).
- Writeback has priority. MDU results are buffered in a small in-order FIFO and drained into idle writeback slots.
- A starvation counter requests a one-cycle pipeline bubble when the buffer is ignored for too long.
- Also drives the execute-stage bypass and a pending-register mask used by decode for hazard stalls.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of 2, ≥2).
- MAX_WAIT, 4, cycles a non-empty FIFO head may go ungranted before stall_req is raised (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- wb_wen  in  1  writeback stage wants to write.
- wb_rd  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- mdu_valid  in  1  MDU result available.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- mdu_ready  out  1  FIFO can accept; transfer occurs when mdu_valid && mdu_ready.
- stall_req  out  1  registered; pipeline must present wb_wen=0 in every cycle this is high.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- fwd_valid  out  1  bypass to execute is valid; equals rf_wen.
- fwd_rd  out  5  bypass register; equals rf_waddr.
- fwd_data  out  32  bypass data; equals rf_wdata.
- pend_mask  out  32  bit r set while a live (unkilled) FIFO entry targets register r; bit 0 is always 0.
- proto_err  out  1  sticky flag: wb_wen was seen while stall_req was high.

Behaviour:
- Reset: FIFO empty; all kill bits 0; starvation counter 0; stall_req=0; proto_err=0.
  - Combinational outputs during reset: rf_wen=0, fwd_valid=0, mdu_ready=1, pend_mask=0.
  - Applies mid-operation: FIFO contents are discarded, not written back.
- Enqueue:
  - mdu_ready = !full, computed from registered state only. No enqueue when full, even if the head pops in the same cycle.
  - An accepted result with mdu_rd=0 is discarded and not enqueued.
  - An enqueued entry writes at the earliest on the next cycle; there is no same-cycle bypass.
- Grant, combinational, evaluated each cycle:
  - wb_wen && wb_rd≠0: write from writeback; FIFO head not granted.
  - wb_wen && wb_rd=0: rf_wen=0; the slot counts as used, so the head is not granted.
  - !wb_wen && FIFO non-empty: pop head. rf_wen = !head.kill; address/data from head.
  - Otherwise rf_wen=0; rf_waddr and rf_wdata are 0.
- Kill (WAW):
  - A writeback write to rd≠0 sets the kill bit of every FIFO entry with matching rd in that cycle. The writeback instruction is younger.
  - A killed entry still occupies its slot and is popped in a free cycle with rf_wen=0.
  - A result enqueued in the same cycle is not killed by that cycle's writeback.
- pend_mask: OR of one-hot(rd) over valid, unkilled entries, from registered state. Kills and pops are visible the next cycle.
- Starvation:
  - The counter increments when the FIFO is non-empty and the head is not popped; it clears on pop or when the FIFO is empty.
  - When counter = MAX_WAIT−1 and the head is again not popped, stall_req is set at the next edge.
  - stall_req clears at the edge after the head pops. Under a legal protocol this is exactly one cycle.
- Protocol violation:
  - If wb_wen=1 while stall_req=1, writeback still wins, proto_err is set (sticky until reset), and stall_req stays high.
- Pointers: read/write pointers of width log2(DEPTH)+1, wrap-around by overflow. full/empty derive from the MSB compare.

Decomposition:
- Shared package: rf_wr_t struct {rd[4:0], data[31:0]}, REG_W=5, XLEN=32.
- One sub-module, mdu_res_fifo: storage, pointers and per-entry kill bits.
  - Inputs: push, pop, kill_en, kill_rd.
  - Outputs: head, head_kill, full, empty, live_mask.
- Arbitration, starvation counter and flags live in the top module.

Test Plan:
- Idle writeback; MDU pushes rd=5, data=0xDEADBEEF at cycle 0 -> cycle 1: rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; pend_mask[5]=1 in cycle 1 and 0 in cycle 2.
- FIFO holds rd=7; wb_wen=1 with wb_rd=7, data=0x11 -> rf writes 0x11 to r7; entry is later popped with rf_wen=0; pend_mask[7] clears the following cycle.
- DEPTH=2: two pushes with no pops -> mdu_ready=0; a third mdu_valid is held off until a pop; FIFO order is preserved.
- MAX_WAIT=4 with wb_wen=1 continuously and FIFO non-empty -> stall_req=1 in the 5th cycle; bench drops wb_wen; head is written; stall_req=0 on the next cycle.
- wb_wen=1 during stall_req -> writeback write proceeds, proto_err=1 and stays set; stall_req stays high until the head pops.
- Assert rst with two entries queued -> no rf_wen afterwards; pend_mask=0; mdu_ready=1; mdu_rd=0 pushes never produce a write.

Source files
------------

// File: rtl/rf_write_arb_pkg.sv
// Shared types and widths for the register-file write arbiter.
// Imported by the FIFO, the interface users and the top.
package rf_write_arb_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } rf_wr_t;

    function automatic logic [XLEN-1:0] onehot_rd(input logic [REG_W-1:0] rd);
        logic [XLEN-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_write_arb_if.sv
// Pipeline-facing bundle of the register-file write arbiter.
// master = pipeline / MDU side, slave = arbiter.
interface rf_write_arb_if;
    import rf_write_arb_pkg::*;

    logic             wb_wen;
    logic [REG_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             mdu_valid;
    logic [REG_W-1:0] mdu_rd;
    logic [XLEN-1:0]  mdu_data;
    logic             mdu_ready;
    logic             stall_req;
    logic             rf_wen;
    logic [REG_W-1:0] rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             fwd_valid;
    logic [REG_W-1:0] fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic [XLEN-1:0]  pend_mask;
    logic             proto_err;

    modport master (
        output wb_wen, wb_rd, wb_data,
        output mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready, stall_req,
        input  rf_wen, rf_waddr, rf_wdata,
        input  fwd_valid, fwd_rd, fwd_data,
        input  pend_mask, proto_err
    );

    modport slave (
        input  wb_wen, wb_rd, wb_data,
        input  mdu_valid, mdu_rd, mdu_data,
        output mdu_ready, stall_req,
        output rf_wen, rf_waddr, rf_wdata,
        output fwd_valid, fwd_rd, fwd_data,
        output pend_mask, proto_err
    );

endinterface

// File: rtl/rf_write_arb_mdu_res_fifo.sv
// In-order FIFO of MDU results with per-entry kill bits for WAW.
// Killed entries keep their slot until popped.
module mdu_res_fifo
    import rf_write_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  rf_wr_t              i_push_data,
    input  logic                i_pop,
    input  logic                i_kill_en,
    input  logic [REG_W-1:0]    i_kill_rd,
    output rf_wr_t              o_head,
    output logic                o_head_kill,
    output logic                o_full,
    output logic                o_empty,
    output logic [XLEN-1:0]     o_live_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    rf_wr_t           r_mem [DEPTH];
    logic [DEPTH-1:0] r_kill;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    w_count;
    logic [XLEN-1:0]  w_live;

    assign w_count = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign o_head      = r_mem[r_rptr[AW-1:0]];
    assign o_head_kill = r_kill[r_rptr[AW-1:0]];

    // Slot i is valid when its distance from the read pointer is below count.
    always_comb begin
        w_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (PW'(AW'(AW'(i) - r_rptr[AW-1:0])) < w_count && !r_kill[i])
                w_live = w_live | onehot_rd(r_mem[i].rd);
        end
        w_live[0] = 1'b0;
    end

    assign o_live_mask = w_live;

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_kill <= '0;
        end else begin
            if (i_push)
                r_wptr <= r_wptr + 1'b1;
            if (i_pop)
                r_rptr <= r_rptr + 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && r_mem[i].rd == i_kill_rd)
                    r_kill[i] <= 1'b1;
            end
            // The freshly written slot is older-than-nothing: never killed this cycle.
            if (i_push)
                r_kill[r_wptr[AW-1:0]] <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arb.sv
// Register-file write port arbiter: writeback first, buffered MDU results
// drain into idle slots; starvation raises a one-cycle stall request.
module rf_write_arb
    import rf_write_arb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    rf_write_arb_if.slave bus
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    rf_wr_t          w_head;
    logic            w_head_kill;
    logic            w_full;
    logic            w_empty;
    logic [XLEN-1:0] w_live;
    logic            w_push;
    logic            w_pop;
    logic            w_wb_wr;
    logic            w_rf_wen;
    logic [REG_W-1:0] w_waddr;
    logic [XLEN-1:0] w_wdata;
    logic [CW-1:0]   r_cnt;
    logic            r_stall;
    logic            r_perr;

    assign bus.mdu_ready = !w_full;
    assign w_push  = bus.mdu_valid && !w_full && (bus.mdu_rd != '0);
    assign w_wb_wr = !rst && bus.wb_wen && (bus.wb_rd != '0);
    assign w_pop   = !rst && !bus.wb_wen && !w_empty;

    mdu_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ('{rd: bus.mdu_rd, data: bus.mdu_data}),
        .i_pop       (w_pop),
        .i_kill_en   (w_wb_wr),
        .i_kill_rd   (bus.wb_rd),
        .o_head      (w_head),
        .o_head_kill (w_head_kill),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_live_mask (w_live)
    );

    always_comb begin
        w_rf_wen = 1'b0;
        w_waddr  = '0;
        w_wdata  = '0;
        unique case (1'b1)
            w_wb_wr: begin
                w_rf_wen = 1'b1;
                w_waddr  = bus.wb_rd;
                w_wdata  = bus.wb_data;
            end
            w_pop: begin
                w_rf_wen = !w_head_kill;
                w_waddr  = w_head.rd;
                w_wdata  = w_head.data;
            end
            default: ;
        endcase
    end

    assign bus.rf_wen    = w_rf_wen;
    assign bus.rf_waddr  = w_waddr;
    assign bus.rf_wdata  = w_wdata;
    assign bus.fwd_valid = w_rf_wen;
    assign bus.fwd_rd    = w_waddr;
    assign bus.fwd_data  = w_wdata;
    assign bus.pend_mask = w_live;
    assign bus.stall_req = r_stall;
    assign bus.proto_err = r_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_stall <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            if (w_empty || w_pop) begin
                r_cnt   <= '0;
                r_stall <= 1'b0;
            end else begin
                // Saturate so a violating pipeline keeps the request up.
                if (r_cnt != CW'(MAX_WAIT - 1))
                    r_cnt <= r_cnt + 1'b1;
                else
                    r_stall <= 1'b1;
            end
            if (bus.wb_wen && r_stall)
                r_perr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_arb.sv
// Directed self-checking bench for rf_write_arb (DEPTH=2, MAX_WAIT=4).
// Inputs change 1 time unit after posedge; outputs checked 2 units after.
module tb_rf_write_arb;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rf_write_arb_if bus();

    rf_write_arb #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd,
                      input logic [31:0] d);
        bus.wb_wen  = en;
        bus.wb_rd   = rd;
        bus.wb_data = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] rd,
                       input logic [31:0] d);
        bus.mdu_valid = v;
        bus.mdu_rd    = rd;
        bus.mdu_data  = d;
    endtask

    task automatic chk_wr(input string tag, input logic en,
                          input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_wen"}, 32'(bus.rf_wen), 32'(en));
        chk({tag, "_fwdv"}, 32'(bus.fwd_valid), 32'(en));
        if (en) begin
            chk({tag, "_addr"}, 32'(bus.rf_waddr), 32'(rd));
            chk({tag, "_data"}, bus.rf_wdata, d);
            chk({tag, "_fwdrd"}, 32'(bus.fwd_rd), 32'(rd));
            chk({tag, "_fwdd"}, bus.fwd_data, d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 0;
        rst    = 1;
        wb(1, 3, 32'h3);
        mdu(0, 0, 0);
        tick();
        #1;
        chk("rst_wen", 32'(bus.rf_wen), 0);
        chk("rst_ready", 32'(bus.mdu_ready), 1);
        chk("rst_pend", bus.pend_mask, 0);
        chk("rst_stall", 32'(bus.stall_req), 0);
        chk("rst_perr", 32'(bus.proto_err), 0);
        wb(0, 0, 0);
        tick();
        rst = 0;
        tick();

        // Simple drain of one result, no same-cycle bypass
        mdu(1, 5, 32'hDEADBEEF);
        #1;
        chk_wr("t1c0", 0, 0, 0);
        tick();
        mdu(0, 0, 0);
        #1;
        chk_wr("t1c1", 1, 5, 32'hDEADBEEF);
        chk("t1c1_pend", bus.pend_mask, 32'h20);
        tick();
        #1;
        chk("t1c2_pend", bus.pend_mask, 0);
        chk_wr("t1c2", 0, 0, 0);
        chk("t1c2_addr0", 32'(bus.rf_waddr), 0);
        chk("t1c2_data0", bus.rf_wdata, 0);

        // WAW kill of a queued entry
        mdu(1, 7, 32'h77);
        wb(1, 3, 32'h33);
        #1;
        chk_wr("t2a", 1, 3, 32'h33);
        tick();
        mdu(0, 0, 0);
        wb(1, 7, 32'h11);
        #1;
        chk_wr("t2b", 1, 7, 32'h11);
        chk("t2b_pend", bus.pend_mask, 32'h80);
        tick();
        wb(0, 0, 0);
        #1;
        chk("t2c_pend", bus.pend_mask, 0);
        chk("t2c_wen", 32'(bus.rf_wen), 0);
        tick();
        #1;
        chk("t2d_ready", 32'(bus.mdu_ready), 1);
        chk("t2d_wen", 32'(bus.rf_wen), 0);

        // Same-cycle enqueue is not killed
        mdu(1, 9, 32'h99);
        wb(1, 9, 32'h90);
        #1;
        chk_wr("t2e", 1, 9, 32'h90);
        tick();
        mdu(0, 0, 0);
        wb(0, 0, 0);
        #1;
        chk_wr("t2f", 1, 9, 32'h99);
        chk("t2f_pend", bus.pend_mask, 32'h200);
        tick();

        // Full FIFO backpressure and ordering
        mdu(1, 10, 32'hA);
        wb(1, 1, 32'h1);
        tick();
        mdu(1, 11, 32'hB);
        wb(1, 2, 32'h2);
        #1;
        chk("t3h_ready", 32'(bus.mdu_ready), 1);
        tick();
        mdu(1, 12, 32'hC);
        wb(1, 4, 32'h4);
        #1;
        chk("t3i_ready", 32'(bus.mdu_ready), 0);
        chk("t3i_pend", bus.pend_mask, 32'hC00);
        tick();
        wb(0, 0, 0);
        #1;
        chk("t3j_ready", 32'(bus.mdu_ready), 0);
        chk_wr("t3j", 1, 10, 32'hA);
        tick();
        #1;
        chk("t3k_ready", 32'(bus.mdu_ready), 1);
        chk_wr("t3k", 1, 11, 32'hB);
        tick();
        mdu(0, 0, 0);
        #1;
        chk_wr("t3l", 1, 12, 32'hC);
        tick();
        #1;
        chk_wr("t3m", 0, 0, 0);
        chk("t3m_stall", 32'(bus.stall_req), 0);

        // Starvation: stall_req in the 5th blocked cycle
        mdu(1, 13, 32'hD);
        wb(1, 1, 32'h1);
        tick();
        mdu(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_nostall", 32'(bus.stall_req), 0);
            tick();
        end
        wb(0, 0, 0);
        #1;
        chk("t4_stall", 32'(bus.stall_req), 1);
        chk_wr("t4_pop", 1, 13, 32'hD);
        tick();
        #1;
        chk("t4_clear", 32'(bus.stall_req), 0);
        chk("t4_perr", 32'(bus.proto_err), 0);

        // Protocol violation during stall
        mdu(1, 14, 32'hE);
        wb(1, 1, 32'h1);
        tick();
        mdu(0, 0, 0);
        repeat (4) tick();
        wb(1, 15, 32'hF);
        #1;
        chk("t5_stall", 32'(bus.stall_req), 1);
        chk_wr("t5_wb", 1, 15, 32'hF);
        tick();
        wb(0, 0, 0);
        #1;
        chk("t5_perr", 32'(bus.proto_err), 1);
        chk("t5_stall2", 32'(bus.stall_req), 1);
        chk_wr("t5_pop", 1, 14, 32'hE);
        tick();
        #1;
        chk("t5_clear", 32'(bus.stall_req), 0);
        chk("t5_sticky", 32'(bus.proto_err), 1);

        // Mid-operation reset discards queued entries
        mdu(1, 16, 32'h16);
        wb(1, 1, 32'h1);
        tick();
        mdu(1, 17, 32'h17);
        tick();
        mdu(0, 0, 0);
        #1;
        chk("t6_pend_pre", bus.pend_mask, 32'h30000);
        chk("t6_ready_pre", 32'(bus.mdu_ready), 0);
        wb(0, 0, 0);
        rst = 1;
        #1;
        chk("t6_pend", bus.pend_mask, 0);
        chk("t6_ready", 32'(bus.mdu_ready), 1);
        chk("t6_wen", 32'(bus.rf_wen), 0);
        chk("t6_perr", 32'(bus.proto_err), 0);
        tick();
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t6_nowr", 32'(bus.rf_wen), 0);
        end

        // rd=0 results are dropped
        mdu(1, 0, 32'h55);
        #1;
        chk("t6_r0_ready", 32'(bus.mdu_ready), 1);
        tick();
        mdu(0, 0, 0);
        #1;
        chk("t6_r0_wen", 32'(bus.rf_wen), 0);
        chk("t6_r0_pend", bus.pend_mask, 0);
        tick();
        #1;
        chk("t6_r0_wen2", 32'(bus.rf_wen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
